// File: rtl/toggle_rx_pkg.sv
// toggle_rx_pkg: shared defaults and FSM state type for the two-phase receiver
package toggle_rx_pkg;
    localparam int DEF_WIDTH       = 8;
    localparam int DEF_SYNC_STAGES = 2;
    localparam int CNT_W           = 16;
    typedef enum logic {IDLE, HOLD} state_t;
endpackage

// File: rtl/toggle_sync.sv
// toggle_sync: multi-flop synchronizer for a slowly changing level signal
module toggle_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);
    logic [STAGES-1:0] r_chain;
    always_ff @(posedge clk)
        r_chain <= reset ? '0 : {r_chain[STAGES-2:0], d};
    assign q = r_chain[STAGES-1];
endmodule

// File: rtl/toggle_rx.sv
// toggle_rx: two-phase (toggle) request receiver with valid/ready output,
// two-phase acknowledge, sticky overrun flag and consumed-word counter
module toggle_rx
    import toggle_rx_pkg::*;
#(
    parameter int WIDTH       = DEF_WIDTH,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             req_tgl,
    input  logic [WIDTH-1:0] data_in,
    output logic             ack_tgl,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic             err_overrun,
    output logic [CNT_W-1:0] evt_count
);
    state_t r_state;
    logic   r_req_prev;
    logic   w_req_s, w_edge, w_take, w_cons;

    toggle_sync #(.STAGES(SYNC_STAGES)) u_sync (
        .clk  (clk),
        .reset(reset),
        .d    (req_tgl),
        .q    (w_req_s)
    );

    assign w_edge = w_req_s ^ r_req_prev;
    assign w_take = (r_state == IDLE) && w_edge && enable;
    assign w_cons = (r_state == HOLD) && out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_req_prev  <= 1'b0;
            ack_tgl     <= 1'b0;
            out_valid   <= 1'b0;
            out_data    <= '0;
            err_overrun <= 1'b0;
            evt_count   <= '0;
        end else begin
            // while idle and disabled, req_prev is frozen so the edge stays pending
            if (r_state == HOLD || enable)
                r_req_prev <= w_req_s;
            if (w_take) begin
                out_data  <= data_in;
                out_valid <= 1'b1;
                r_state   <= HOLD;
            end
            if (w_cons) begin
                out_valid <= 1'b0;
                ack_tgl   <= ~ack_tgl;
                evt_count <= evt_count + CNT_W'(1);
                r_state   <= IDLE;
            end
            if (r_state == HOLD && w_edge)
                err_overrun <= 1'b1;
        end
    end
endmodule

// File: tb/tb_toggle_rx.sv
// tb_toggle_rx: directed self-checking bench for toggle_rx
module tb_toggle_rx;
    logic        clk = 1'b0;
    logic        reset, enable, req_tgl, out_ready;
    logic [7:0]  data_in;
    logic        ack_tgl, out_valid, err_overrun;
    logic [7:0]  out_data;
    logic [15:0] evt_count;
    int checks = 0;
    int errors = 0;

    toggle_rx dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .req_tgl    (req_tgl),
        .data_in    (data_in),
        .ack_tgl    (ack_tgl),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_ready  (out_ready),
        .err_overrun(err_overrun),
        .evt_count  (evt_count)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1; enable = 1'b1; req_tgl = 1'b0; out_ready = 1'b1; data_in = 8'h00;
        step(2);
        reset = 1'b0;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_data", 32'(out_data), 32'h00);
        chk("rst_ack", 32'(ack_tgl), 32'd0);
        chk("rst_err", 32'(err_overrun), 32'd0);
        chk("rst_cnt", 32'(evt_count), 32'd0);

        // single word: valid after the 3rd edge, consumed on the 4th
        data_in = 8'hA5; req_tgl = 1'b1;
        step(1); chk("w1_lat1", 32'(out_valid), 32'd0);
        step(1); chk("w1_lat2", 32'(out_valid), 32'd0);
        step(1); chk("w1_valid", 32'(out_valid), 32'd1);
        chk("w1_data", 32'(out_data), 32'hA5);
        chk("w1_ack_pre", 32'(ack_tgl), 32'd0);
        step(1); chk("w1_valid_off", 32'(out_valid), 32'd0);
        chk("w1_ack", 32'(ack_tgl), 32'd1);
        chk("w1_cnt", 32'(evt_count), 32'd1);

        // backpressure
        out_ready = 1'b0; data_in = 8'h3C; req_tgl = 1'b0;
        step(3);
        for (int i = 0; i < 10; i++) begin
            chk("bp_valid", 32'(out_valid), 32'd1);
            chk("bp_data", 32'(out_data), 32'h3C);
            chk("bp_ack", 32'(ack_tgl), 32'd1);
            step(1);
        end
        out_ready = 1'b1;
        step(1); chk("bp_valid_off", 32'(out_valid), 32'd0);
        chk("bp_ack", 32'(ack_tgl), 32'd0);
        chk("bp_cnt", 32'(evt_count), 32'd2);

        // enable gating
        enable = 1'b0; data_in = 8'h11; req_tgl = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step(1); chk("en_hold", 32'(out_valid), 32'd0);
        end
        enable = 1'b1;
        step(1); chk("en_valid", 32'(out_valid), 32'd1);
        chk("en_data", 32'(out_data), 32'h11);
        step(1); chk("en_ack", 32'(ack_tgl), 32'd1);
        chk("en_cnt", 32'(evt_count), 32'd3);

        // overrun
        out_ready = 1'b0; data_in = 8'h01; req_tgl = 1'b0;
        step(3); chk("ov_valid", 32'(out_valid), 32'd1);
        chk("ov_err_pre", 32'(err_overrun), 32'd0);
        data_in = 8'h02; req_tgl = 1'b1;
        step(3); chk("ov_err", 32'(err_overrun), 32'd1);
        chk("ov_data", 32'(out_data), 32'h01);
        chk("ov_valid2", 32'(out_valid), 32'd1);
        out_ready = 1'b1;
        step(1); chk("ov_valid_off", 32'(out_valid), 32'd0);
        chk("ov_ack", 32'(ack_tgl), 32'd0);
        chk("ov_cnt", 32'(evt_count), 32'd4);
        step(5); chk("ov_ack_once", 32'(ack_tgl), 32'd0);
        chk("ov_no_recapture", 32'(out_valid), 32'd0);
        chk("ov_sticky", 32'(err_overrun), 32'd1);

        // reset while holding a word
        out_ready = 1'b0; data_in = 8'h77; req_tgl = 1'b0;
        step(3); chk("rh_valid", 32'(out_valid), 32'd1);
        reset = 1'b1; req_tgl = 1'b0;
        step(1); reset = 1'b0;
        chk("rh_valid0", 32'(out_valid), 32'd0);
        chk("rh_data0", 32'(out_data), 32'h00);
        chk("rh_ack0", 32'(ack_tgl), 32'd0);
        chk("rh_err0", 32'(err_overrun), 32'd0);
        chk("rh_cnt0", 32'(evt_count), 32'd0);
        step(3); chk("rh_ack_still", 32'(ack_tgl), 32'd0);
        out_ready = 1'b1; data_in = 8'h5A; req_tgl = 1'b1;
        step(3); chk("rh_next_valid", 32'(out_valid), 32'd1);
        chk("rh_next_data", 32'(out_data), 32'h5A);
        step(1); chk("rh_next_ack", 32'(ack_tgl), 32'd1);
        chk("rh_next_cnt", 32'(evt_count), 32'd1);

        // counter wrap
        force dut.evt_count = 16'hFFFF;
        #1 release dut.evt_count;
        data_in = 8'hC3; req_tgl = 1'b0;
        step(3); chk("wr_valid", 32'(out_valid), 32'd1);
        step(1); chk("wr_cnt", 32'(evt_count), 32'h0000);
        chk("wr_err", 32'(err_overrun), 32'd0);
        chk("wr_ack", 32'(ack_tgl), 32'd0);
        req_tgl = 1'b1;
        step(4); chk("wr_cnt_next", 32'(evt_count), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/toggle_rx.md
TOGGLE_RX -- requirements
Module: toggle_rx

Interface
REQ-001 Parameter WIDTH, default 8: payload width in bits.
REQ-002 Parameter SYNC_STAGES, default 2: flops in the req_tgl synchronizer; minimum 2.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 enable  input  1  high: new events are accepted; low: new events are held pending.
REQ-006 req_tgl  input  1  two-phase request; each level change signals one new word; asynchronous to clk.
REQ-007 data_in  input  WIDTH  payload; sender holds it stable from the req_tgl change until the matching ack_tgl change.
REQ-008 ack_tgl  output  1  two-phase acknowledge; toggles once per consumed word.
REQ-009 out_valid  output  1  out_data holds an unconsumed word.
REQ-010 out_data  output  WIDTH  captured payload.
REQ-011 out_ready  input  1  downstream accepts out_data when high with out_valid.
REQ-012 err_overrun  output  1  sticky flag: req_tgl changed while a word was still unconsumed.
REQ-013 evt_count  output  16  count of words consumed downstream.

Function
REQ-014 req_tgl SHALL pass through a SYNC_STAGES-flop chain; req_s is the last stage, and req_prev is req_s registered.
REQ-015 edge SHALL be defined as req_s XOR req_prev.
REQ-016 The FSM SHALL have two states: IDLE and HOLD.
REQ-017 IDLE with edge=1 and enable=1: data_in is captured into out_data, out_valid is set to 1, req_prev is updated, and the state moves to HOLD.
REQ-018 IDLE with enable=0: req_prev is not updated, so the edge stays pending and is accepted on the first edge after enable returns high.
REQ-019 Latency: out_valid SHALL rise after the (SYNC_STAGES+1)-th rising edge that samples the new req_tgl level (3 edges with the default).
REQ-020 HOLD with out_valid=1 and out_ready=1: out_valid is cleared, ack_tgl is inverted, evt_count is incremented, and the state moves to IDLE, all in one edge.
REQ-021 The HOLD handshake SHALL complete regardless of enable.
REQ-022 HOLD with edge=1: err_overrun is set to 1, req_prev is updated, the new event is dropped, and out_data is unchanged.
REQ-023 If the handshake (REQ-020) and an overrun edge (REQ-022) occur on the same edge, both SHALL take effect, and the state returns to IDLE.
REQ-024 out_data SHALL change only on capture; it SHALL be stable for the whole of HOLD.
REQ-025 evt_count SHALL wrap from 0xFFFF to 0x0000.
REQ-026 err_overrun SHALL clear only on reset.
REQ-027 ack_tgl SHALL never toggle more than once per accepted word.

Reset
REQ-028 Reset SHALL set all of the following to 0: sync chain, req_prev, ack_tgl, out_valid, out_data, err_overrun and evt_count. The state SHALL become IDLE.
REQ-029 A reset asserted in HOLD SHALL drop the word with no ack_tgl toggle; the sender is reset with its req_tgl at 0.
REQ-030 Reset SHALL have priority over every other input on the same edge.

Structure
REQ-031 Package toggle_rx_pkg SHALL hold the FSM state enum and the default values for WIDTH, SYNC_STAGES and the evt_count width.
REQ-032 The synchronizer SHALL be sub-module toggle_sync, parameterised by stage count, with ports clk, reset, d and q.

Verification
REQ-033 Single word: reset, then req_tgl 0->1 with data_in=0xA5 and out_ready=1. Required: out_valid rises 3 edges later with out_data=0xA5 and is high for 1 cycle, then ack_tgl=1 and evt_count=1.
REQ-034 Backpressure: out_ready=0 and a toggle with data 0x3C. Required: out_valid stays high and out_data=0x3C for 10 cycles. Then out_ready=1: 1 edge later out_valid=0 and ack_tgl toggles.
REQ-035 Enable gating: enable=0 and a toggle with data 0x11. Required: out_valid stays 0 for 20 cycles. Then enable=1: out_valid rises on the next edge with out_data=0x11.
REQ-036 Overrun: out_ready=0, toggle with data 0x01, then toggle again with data 0x02. Required: err_overrun=1, out_data=0x01, and exactly 1 ack_tgl toggle after out_ready=1.
REQ-037 Reset mid-HOLD: reset for 1 cycle while out_valid=1. Required: all outputs 0, no ack_tgl toggle, and the next toggle is accepted normally.
REQ-038 Wrap: preload evt_count via 65536 words (or force). Required: evt_count reads 0x0000 after the 65536th consume, and err_overrun stays 0.
